// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, the data port and the shared memory port of mem_port_arbiter.
// The arbiter uses "slave"; the pipeline/memory side (or a bench) uses "master".
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic [DW-1:0] if_rdata;
    logic          if_rvalid;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic [DW-1:0] dm_rdata;
    logic          dm_rvalid;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_rdata, if_rvalid, dm_gnt, dm_rdata, dm_rvalid,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_rdata, if_rvalid, dm_gnt, dm_rdata, dm_rvalid,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the fetch port (read-only)
// and the data port (read/write); data has priority, a starvation counter protects fetch.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 2
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    // state  | meaning
    // IDLE   | no transaction; arbitrate on every edge
    // ACCESS | one cycle: winner's gnt, memory strobe with latched request
    // WAIT   | count down the memory latency, capture read data on the last cycle
    // RESP   | one cycle: winner's rvalid with captured data; arbitrate the next request
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam int LW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [LW-1:0] LAT_LOAD   = LW'(MEM_LAT);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    state_t        state_q, state_d;
    logic          winner_dm_q, winner_dm_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [LW-1:0] lat_cnt_q, lat_cnt_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          if_win, dm_win;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            winner_dm_q  <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            winner_dm_q  <= winner_dm_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        winner_dm_d  = winner_dm_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;

        // Fetch only beats a pending data request once it has lost STARVE_MAX times.
        if_win = bus.if_req && (!bus.dm_req || (starve_cnt_q == STARVE_TOP));
        dm_win = bus.dm_req && !if_win;

        unique case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (if_win) begin
                    state_d      = ACCESS;
                    winner_dm_d  = 1'b0;
                    we_d         = 1'b0;
                    addr_d       = bus.if_addr;
                    wdata_d      = '0;
                    starve_cnt_d = '0;
                end else if (dm_win) begin
                    state_d     = ACCESS;
                    winner_dm_d = 1'b1;
                    we_d        = bus.dm_we;
                    addr_d      = bus.dm_addr;
                    wdata_d     = bus.dm_wdata;
                    if (bus.if_req && (starve_cnt_q != STARVE_TOP)) begin
                        starve_cnt_d = starve_cnt_q + SW'(1);
                    end
                end
            end
            ACCESS: begin
                lat_cnt_d = LAT_LOAD;
                state_d   = WAIT;
            end
            WAIT: begin
                lat_cnt_d = lat_cnt_q - LW'(1);
                if (lat_cnt_q == LW'(1)) begin
                    rdata_d = we_q ? '0 : bus.mem_rdata;
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.if_gnt    = 1'b0;
        bus.dm_gnt    = 1'b0;
        bus.if_rvalid = 1'b0;
        bus.dm_rvalid = 1'b0;
        bus.if_rdata  = '0;
        bus.dm_rdata  = '0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.busy      = (state_q != IDLE);

        unique case (state_q)
            ACCESS: begin
                bus.if_gnt    = !winner_dm_q;
                bus.dm_gnt    = winner_dm_q;
                bus.mem_en    = 1'b1;
                bus.mem_we    = we_q;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wdata_q;
            end
            RESP: begin
                if (winner_dm_q) begin
                    bus.dm_rvalid = 1'b1;
                    bus.dm_rdata  = rdata_q;
                end else begin
                    bus.if_rvalid = 1'b1;
                    bus.if_rdata  = rdata_q;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: MEM_LAT=2 instance for most scenarios,
// MEM_LAT=1 instance for back-to-back throughput.
module tb_mem_port_arbiter;
    logic clk;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic sel = 1'b0;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus0 ();
    mem_port_arbiter_if #(.AW(32), .DW(32)) bus1 ();

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .STARVE_MAX(2)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(2)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: registered read pipeline of MEM_LAT stages, junk outside valid cycle.
    logic [31:0] mem0 [64];
    logic [31:0] pipe0 [2];
    logic [31:0] pipe1;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem0[i] <= 32'(i) * 32'h0101_0101;
            mem0[1] <= 32'hCAFE_F00D;
            mem0[4] <= 32'hDEAD_BEEF;
        end else if (bus0.mem_en && bus0.mem_we) begin
            mem0[bus0.mem_addr[7:2]] <= bus0.mem_wdata;
        end
        pipe0[0] <= (bus0.mem_en && !bus0.mem_we) ? mem0[bus0.mem_addr[7:2]]
                                                  : (32'hBAD0_0000 | 32'(cyc));
        pipe0[1] <= pipe0[0];
        pipe1    <= (bus1.mem_en && !bus1.mem_we) ? (bus1.mem_addr ^ 32'hA5A5_0000)
                                                  : (32'hBAD1_0000 | 32'(cyc));
    end
    assign bus0.mem_rdata = pipe0[1];
    assign bus1.mem_rdata = pipe1;

    typedef struct {
        logic        dm;
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } gexp_t;
    typedef struct {
        logic        dm;
        int          cyc;
        logic [31:0] data;
    } rexp_t;
    gexp_t gq[$];
    rexp_t rq[$];
    gexp_t g;
    rexp_t r;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_cmp++;
        if (obs !== expd) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", tag, obs, expd, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_gnt(input logic dm, input int c, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        gq.push_back('{dm: dm, cyc: c, we: we, addr: addr, wdata: wdata});
    endtask

    task automatic exp_rv(input logic dm, input int c, input logic [31:0] data);
        rq.push_back('{dm: dm, cyc: c, data: data});
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (gq.size() != 0 || rq.size() != 0); i++) step();
        check_eq("drain", 32'(gq.size() + rq.size()), 32'd0);
        step();
    endtask

    task automatic check_idle0(input string tag);
        check_eq({tag, "_busy"},      32'(bus0.busy),      32'd0);
        check_eq({tag, "_if_gnt"},    32'(bus0.if_gnt),    32'd0);
        check_eq({tag, "_dm_gnt"},    32'(bus0.dm_gnt),    32'd0);
        check_eq({tag, "_if_rvalid"}, 32'(bus0.if_rvalid), 32'd0);
        check_eq({tag, "_dm_rvalid"}, 32'(bus0.dm_rvalid), 32'd0);
        check_eq({tag, "_mem_en"},    32'(bus0.mem_en),    32'd0);
        check_eq({tag, "_mem_we"},    32'(bus0.mem_we),    32'd0);
        check_eq({tag, "_mem_addr"},  bus0.mem_addr,       32'd0);
        check_eq({tag, "_mem_wdata"}, bus0.mem_wdata,      32'd0);
        check_eq({tag, "_if_rdata"},  bus0.if_rdata,       32'd0);
        check_eq({tag, "_dm_rdata"},  bus0.dm_rdata,       32'd0);
    endtask

    logic        m_if_gnt, m_dm_gnt, m_if_rv, m_dm_rv, m_en, m_we;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
    always_comb begin
        m_if_gnt   = sel ? bus1.if_gnt    : bus0.if_gnt;
        m_dm_gnt   = sel ? bus1.dm_gnt    : bus0.dm_gnt;
        m_if_rv    = sel ? bus1.if_rvalid : bus0.if_rvalid;
        m_dm_rv    = sel ? bus1.dm_rvalid : bus0.dm_rvalid;
        m_en       = sel ? bus1.mem_en    : bus0.mem_en;
        m_we       = sel ? bus1.mem_we    : bus0.mem_we;
        m_addr     = sel ? bus1.mem_addr  : bus0.mem_addr;
        m_wdata    = sel ? bus1.mem_wdata : bus0.mem_wdata;
        m_if_rdata = sel ? bus1.if_rdata  : bus0.if_rdata;
        m_dm_rdata = sel ? bus1.dm_rdata  : bus0.dm_rdata;
    end

    always @(negedge clk) begin
        check_eq("gnt_excl", 32'(m_if_gnt & m_dm_gnt), 32'd0);
        check_eq("rv_excl", 32'(m_if_rv & m_dm_rv), 32'd0);
        check_eq("en_vs_gnt", 32'(m_en), 32'(m_if_gnt | m_dm_gnt));
        check_eq("we_wo_en", 32'(m_we & ~m_en), 32'd0);
        if (m_if_gnt || m_dm_gnt) begin
            if (gq.size() == 0) begin
                check_eq("gnt_unexpected", 32'd1, 32'd0);
            end else begin
                g = gq.pop_front();
                check_eq("gnt_port_dm", 32'(m_dm_gnt), 32'(g.dm));
                check_eq("gnt_cycle", 32'(cyc), 32'(g.cyc));
                check_eq("mem_we", 32'(m_we), 32'(g.we));
                check_eq("mem_addr", m_addr, g.addr);
                if (g.we) check_eq("mem_wdata", m_wdata, g.wdata);
            end
        end
        if (m_if_rv || m_dm_rv) begin
            if (rq.size() == 0) begin
                check_eq("rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                r = rq.pop_front();
                check_eq("rv_port_dm", 32'(m_dm_rv), 32'(r.dm));
                check_eq("rv_cycle", 32'(cyc), 32'(r.cyc));
                check_eq("rdata", m_dm_rv ? m_dm_rdata : m_if_rdata, r.data);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: bench still running at cycle %0d, required finish", cyc);
        $fatal(1, "timeout");
    end

    int T;
    int st_exp[6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        reset = 1'b1;
        bus0.if_req = 1'b0; bus0.if_addr = '0; bus0.dm_req = 1'b0; bus0.dm_we = 1'b0;
        bus0.dm_addr = '0; bus0.dm_wdata = '0;
        bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.dm_req = 1'b0; bus1.dm_we = 1'b0;
        bus1.dm_addr = '0; bus1.dm_wdata = '0;
        repeat (3) step();
        @(negedge clk);
        check_idle0("reset");
        check_eq("reset_starve", 32'(dut0.starve_cnt_q), 32'd0);
        step();
        reset = 1'b0;
        step();

        // Fetch read of 0x10, busy window T+1..T+4
        T = cyc;
        bus0.if_req = 1'b1; bus0.if_addr = 32'h10;
        exp_gnt(1'b0, T + 1, 1'b0, 32'h10, 32'h0);
        exp_rv(1'b0, T + 4, 32'hDEAD_BEEF);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            check_eq("busy_fetch", 32'(bus0.busy), 32'((k >= 1) && (k <= 4)));
            step();
            if (k == 0) bus0.if_req = 1'b0;
        end
        drain();

        // Simultaneous requests: data first, fetch follows at T+5
        T = cyc;
        bus0.if_req = 1'b1; bus0.if_addr = 32'h10;
        bus0.dm_req = 1'b1; bus0.dm_we = 1'b0; bus0.dm_addr = 32'h04;
        exp_gnt(1'b1, T + 1, 1'b0, 32'h04, 32'h0);
        exp_rv(1'b1, T + 4, 32'hCAFE_F00D);
        exp_gnt(1'b0, T + 5, 1'b0, 32'h10, 32'h0);
        exp_rv(1'b0, T + 8, 32'hDEAD_BEEF);
        step();
        bus0.dm_req = 1'b0;
        repeat (5) step();
        bus0.if_req = 1'b0;
        drain();

        // Starvation: both held, grants dm dm if dm dm if
        T = cyc;
        bus0.if_req = 1'b1; bus0.if_addr = 32'h10;
        bus0.dm_req = 1'b1; bus0.dm_we = 1'b0; bus0.dm_addr = 32'h04;
        for (int i = 0; i < 6; i++) begin
            if (i % 3 != 2) begin
                exp_gnt(1'b1, T + 1 + 4 * i, 1'b0, 32'h04, 32'h0);
                exp_rv(1'b1, T + 4 + 4 * i, 32'hCAFE_F00D);
            end else begin
                exp_gnt(1'b0, T + 1 + 4 * i, 1'b0, 32'h10, 32'h0);
                exp_rv(1'b0, T + 4 + 4 * i, 32'hDEAD_BEEF);
            end
        end
        for (int k = 0; k <= 22; k++) begin
            @(negedge clk);
            if ((k % 4 == 0) && (k <= 20)) check_eq("starve_cnt", 32'(dut0.starve_cnt_q), 32'(st_exp[k / 4]));
            step();
        end
        bus0.if_req = 1'b0; bus0.dm_req = 1'b0;
        drain();

        // Write 0x20 then read it back, read issued in the write's RESP cycle
        T = cyc;
        bus0.dm_req = 1'b1; bus0.dm_we = 1'b1; bus0.dm_addr = 32'h20; bus0.dm_wdata = 32'h1234_5678;
        exp_gnt(1'b1, T + 1, 1'b1, 32'h20, 32'h1234_5678);
        exp_rv(1'b1, T + 4, 32'h0);
        step();
        bus0.dm_req = 1'b0; bus0.dm_we = 1'b0; bus0.dm_wdata = '0;
        repeat (3) step();
        bus0.dm_req = 1'b1;
        exp_gnt(1'b1, T + 5, 1'b0, 32'h20, 32'h0);
        exp_rv(1'b1, T + 8, 32'h1234_5678);
        step();
        bus0.dm_req = 1'b0;
        drain();

        // Reset during WAIT drops the transaction and clears the starvation count
        T = cyc;
        bus0.if_req = 1'b1; bus0.if_addr = 32'h10;
        bus0.dm_req = 1'b1; bus0.dm_we = 1'b0; bus0.dm_addr = 32'h04;
        exp_gnt(1'b1, T + 1, 1'b0, 32'h04, 32'h0);
        step();
        bus0.dm_req = 1'b0;
        step();
        reset = 1'b1;
        bus0.if_req = 1'b0;
        @(negedge clk);
        check_eq("starve_before_reset", 32'(dut0.starve_cnt_q), 32'd1);
        step();
        reset = 1'b0;
        @(negedge clk);
        check_idle0("midreset");
        check_eq("midreset_starve", 32'(dut0.starve_cnt_q), 32'd0);
        repeat (6) step();
        T = cyc;
        bus0.if_req = 1'b1; bus0.if_addr = 32'h10;
        exp_gnt(1'b0, T + 1, 1'b0, 32'h10, 32'h0);
        exp_rv(1'b0, T + 4, 32'hDEAD_BEEF);
        step();
        bus0.if_req = 1'b0;
        drain();

        // MEM_LAT=1 back-to-back data reads: gnt every 3 cycles
        sel = 1'b1;
        step();
        T = cyc;
        bus1.dm_req = 1'b1; bus1.dm_we = 1'b0; bus1.dm_addr = 32'h08;
        for (int i = 0; i < 3; i++) begin
            exp_gnt(1'b1, T + 1 + 3 * i, 1'b0, 32'h08, 32'h0);
            exp_rv(1'b1, T + 3 + 3 * i, 32'hA5A5_0008);
        end
        repeat (7) step();
        bus1.dm_req = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency instruction/data memory between two requesters: the fetch stage (read-only) and the memory-access stage (read/write).
- Sequences each access through a small FSM and returns read data with a valid pulse.
- Data port has priority; a starvation counter guarantees fetch progress.
- Sits between the pipeline's IF/MEM stages and the shared memory macro.

Parameters:
AW, 32, address width of all address ports
DW, 32, data width
MEM_LAT, 2, memory read latency in cycles from mem_en cycle to mem_rdata valid (legal >= 1)
STARVE_MAX, 2, consecutive lost arbitrations after which fetch wins once (legal >= 1)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
if_req  input  1  fetch request; if_addr stable while high
if_addr  input  AW  fetch address
if_gnt  output  1  one-cycle pulse: fetch request accepted
if_rdata  output  DW  fetch read data, valid with if_rvalid
if_rvalid  output  1  one-cycle pulse: fetch data returned
dm_req  input  1  data request; dm_we/addr/wdata stable while high
dm_we  input  1  1 = write, 0 = read
dm_addr  input  AW  data address
dm_wdata  input  DW  write data
dm_gnt  output  1  one-cycle pulse: data request accepted
dm_rdata  output  DW  read data (0 for writes), valid with dm_rvalid
dm_rvalid  output  1  one-cycle pulse: data read returned / write acknowledged
mem_en  output  1  memory access strobe
mem_we  output  1  memory write enable, only ever high with mem_en
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data, valid MEM_LAT cycles after mem_en cycle
busy  output  1  high whenever state != IDLE

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- Reset values:
  - state = IDLE; starve_cnt = 0.
  - All outputs 0: gnt, rvalid, mem_en, mem_we, busy; rdata and mem_addr/mem_wdata also 0.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- Arbitration happens in IDLE and RESP, sampled at the clock edge.
  - Fetch wins if if_req and (!dm_req or starve_cnt == STARVE_MAX); otherwise dm wins if dm_req.
  - On a win, latch winner, addr, we, wdata and go to ACCESS. With no request, RESP/IDLE -> IDLE.
- Starvation counter:
  - starve_cnt increments (saturating at STARVE_MAX) on each arbitration where dm wins while if_req is high.
  - Cleared when fetch wins.
- ACCESS (exactly 1 cycle):
  - Winner's gnt = 1; mem_en = 1; mem_we = latched we; mem_addr and mem_wdata = latched values.
  - Latency counter loaded with MEM_LAT; go to WAIT.
- WAIT:
  - mem_en = 0; counter decrements each cycle.
  - On the cycle mem_rdata is valid (MEM_LAT cycles after ACCESS), capture it (or 0 for a write) and go to RESP.
- RESP (exactly 1 cycle):
  - Winner's rvalid = 1 with captured rdata; the other port's rvalid = 0.
  - Arbitration for the next transaction runs in this same cycle.
- Timing, with a request sampled at edge ending cycle T:
  - gnt and mem_en in T+1.
  - rvalid in T+2+MEM_LAT.
  - Earliest next gnt in T+3+MEM_LAT.
  - Per-port throughput is one transaction per MEM_LAT+2 cycles.
- Requester handshake:
  - A requester may hold req high past gnt only to issue a new transaction.
  - Requests arriving during ACCESS/WAIT are ignored until the next RESP/IDLE.
- Writes: single-cycle mem_we; dm_rvalid still pulses as the write acknowledgement, with dm_rdata = 0.
- Simultaneous if_req and dm_req with starve_cnt < STARVE_MAX: dm wins; if_gnt stays 0.
- Reset mid-operation (any state):
  - Next cycle is IDLE with all outputs 0.
  - The in-flight transaction is dropped: no rvalid is ever produced for it.
  - starve_cnt = 0.
- mem_en and mem_we are never asserted outside ACCESS.
- if_gnt and dm_gnt are never high together; likewise if_rvalid and dm_rvalid.

Test Plan:
- Fetch read, MEM_LAT=2, model returns 0xDEADBEEF at 0x10: if_req in cycle 0 with if_addr=0x10 -> cycle 1 has if_gnt=1, mem_en=1, mem_we=0, mem_addr=0x10; cycle 4 has if_rvalid=1, if_rdata=0xDEADBEEF; busy is high in cycles 1-4.
- Simultaneous if_req and dm_req (dm read of 0x04) from IDLE -> dm_gnt in cycle 1 with if_gnt=0; dm_rvalid in cycle 4; if_gnt in cycle 5.
- Starvation, STARVE_MAX=2, both reqs held high continuously -> grant order dm, dm, if, dm, dm, if; starve_cnt reads 0,1,2,0 across the sequence.
- Write then read: dm_we=1, addr 0x20, data 0x12345678 -> mem_we=1 only in the grant cycle with that data; dm_rvalid=1 with dm_rdata=0. A following dm read of 0x20 returns 0x12345678.
- Reset asserted during WAIT -> next cycle busy=0 with all outputs 0, and no rvalid follows. A subsequent fetch request completes with normal T+1/T+2+MEM_LAT timing.
- MEM_LAT=1, back-to-back: dm_req held high -> gnt pulses every 3 cycles (cycles 1, 4, 7); each dm_rvalid lands in the same cycle in which the next arbitration occurs.
